apb_mux_arbiter: RTL

Parametrised N-to-1 APB arbiter between CPU_NB APB managers (the cpu instances) and one APB subordinate (the memory). Each manager sees a private subordinate port; the arbiter serialises their transfers onto a single registered manager port using round-robin or fixed priority. It is the next-generation interconnect stage for multi-CPU tops: one shared subordinate, any manager count.

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_rr_picker.sv | 36 +++
 rtl/apb_mux_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB transfer types plus the arbiter's limits and FSM state encoding.
package apb_pkg;

    localparam int unsigned APB_ADDR_W         = 32;
    localparam int unsigned APB_DATA_W         = 32;
    localparam int unsigned APB_ARB_MAX_CPU_NB = 32;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] paddr;
        logic                  pwrite;
        logic [APB_DATA_W-1:0] pwdata;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] prdata;
    } apb_resp_t;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } apb_arb_state_e;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational winner select: first requester found scanning upward from i_ptr, wrapping.
// With APB_MUX_ARBITER_FIXED_PRIO_EN defined the scan always starts at 0 (lowest index wins).
module apb_rr_picker
    import apb_pkg::*;
#(
    parameter int unsigned CPU_NB = 4,
    parameter int unsigned IDX_W  = $clog2(CPU_NB)
) (
    input  logic [CPU_NB-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic              o_valid,
    output logic [IDX_W-1:0]  o_idx
);

    logic [IDX_W-1:0] w_start;

`ifdef APB_MUX_ARBITER_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;
    assign w_start      = '0;
`else
    assign w_start = i_ptr;
`endif

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int unsigned i = 0; i < CPU_NB; i++) begin
            if (!o_valid && i_req[(32'(w_start) + i) % CPU_NB]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'((32'(w_start) + i) % CPU_NB);
            end
        end
    end

endmodule

// File: rtl/apb_mux_arbiter.sv
// N-to-1 APB arbiter: serialises CPU_NB managers onto one registered subordinate port.
// Round-robin by default; define APB_MUX_ARBITER_FIXED_PRIO_EN for lowest-index priority.
module apb_mux_arbiter
    import apb_pkg::*;
#(
    parameter  int unsigned CPU_NB = 4,
    localparam int unsigned IDX_W  = $clog2(CPU_NB)
) (
    input  logic              clk,
    input  logic              rst,
    input  apb_req_t          i_apb_s_req     [CPU_NB],
    output apb_resp_t         o_apb_s_resp    [CPU_NB],
    input  logic [CPU_NB-1:0] i_apb_s_psel,
    input  logic [CPU_NB-1:0] i_apb_s_penable,
    output logic [CPU_NB-1:0] o_apb_s_pready,
    output apb_req_t          o_apb_m_req,
    input  apb_resp_t         i_apb_m_resp,
    output logic              o_apb_m_psel,
    output logic              o_apb_m_penable,
    input  logic              i_apb_m_pready,
    output logic              o_grant_valid,
    output logic [IDX_W-1:0]  o_grant_idx
);

    apb_arb_state_e   r_state;
    logic [IDX_W-1:0] r_idx;
    apb_req_t         r_req;
    logic             r_psel;
    logic             r_penable;
    logic             r_grant_valid;
    logic [IDX_W-1:0] w_rr_ptr;
    logic             w_win_valid;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_done;
    logic             w_unused_penable;

    // Managers keep psel high for the whole transfer, so penable carries no extra information.
    assign w_unused_penable = ^i_apb_s_penable;

`ifdef APB_MUX_ARBITER_FIXED_PRIO_EN
    assign w_rr_ptr = '0;
`else
    logic [IDX_W-1:0] r_rr_ptr;
    assign w_rr_ptr = r_rr_ptr;
`endif

    apb_rr_picker #(
        .CPU_NB (CPU_NB),
        .IDX_W  (IDX_W)
    ) u_picker (
        .i_req   (i_apb_s_psel),
        .i_ptr   (w_rr_ptr),
        .o_valid (w_win_valid),
        .o_idx   (w_win_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_idx         <= '0;
            r_req         <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_grant_valid <= 1'b0;
`ifndef APB_MUX_ARBITER_FIXED_PRIO_EN
            r_rr_ptr      <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_win_valid) begin
                        r_state       <= StSetup;
                        r_idx         <= w_win_idx;
                        r_req         <= i_apb_s_req[w_win_idx];
                        r_psel        <= 1'b1;
                        r_penable     <= 1'b0;
                        r_grant_valid <= 1'b1;
`ifndef APB_MUX_ARBITER_FIXED_PRIO_EN
                        r_rr_ptr      <= (w_win_idx == IDX_W'(CPU_NB - 1)) ? '0
                                                                            : w_win_idx + 1'b1;
`endif
                    end
                end
                StSetup: begin
                    r_state   <= StAccess;
                    r_penable <= 1'b1;
                end
                StAccess: begin
                    if (i_apb_m_pready) begin
                        r_state       <= StIdle;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_grant_valid <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_done = (r_state == StAccess) && i_apb_m_pready;

    // Completion is passed straight through in the same cycle the subordinate signals it.
    always_comb begin
        o_apb_s_pready = '0;
        for (int unsigned k = 0; k < CPU_NB; k++) begin
            o_apb_s_resp[k] = '0;
            if (w_done && (r_idx == IDX_W'(k))) begin
                o_apb_s_pready[k] = 1'b1;
                o_apb_s_resp[k]   = i_apb_m_resp;
            end
        end
    end

    assign o_apb_m_req     = r_req;
    assign o_apb_m_psel    = r_psel;
    assign o_apb_m_penable = r_penable;
    assign o_grant_valid   = r_grant_valid;
    assign o_grant_idx     = r_idx;

endmodule
